// File: rtl/countdown_timer_dp.sv
// rtl/countdown_timer_dp.sv - hh:mm:ss:cc countdown timer datapath/control, optional TIMER_AUTORELOAD_EN
module countdown_timer_dp #(
  parameter int FCOUNT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic [6:0] set_msec,
  input  logic       run_stop,
  input  logic       clear,
  input  logic       option,
  output logic [6:0] low_digit,
  output logic [5:0] high_digit,
  output logic       busy,
  output logic       done
);
  localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(FCOUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic [4:0] pre_h, cnt_h, ld_h, dec_h;
  logic [5:0] pre_m, cnt_m, ld_m, dec_m;
  logic [5:0] pre_s, cnt_s, ld_s, dec_s;
  logic [6:0] pre_c, cnt_c, ld_c, dec_c;
  logic b_c, b_s, b_m;
  logic tick, at_one, cnt_nz, preset_nz;
  logic do_load, do_reload, do_zero, do_dec, presc_clr, presc_run, expire;

  assign ld_h = (set_hour > 5'd23) ? 5'd23 : set_hour;
  assign ld_m = (set_min  > 6'd59) ? 6'd59 : set_min;
  assign ld_s = (set_sec  > 6'd59) ? 6'd59 : set_sec;
  assign ld_c = (set_msec > 7'd99) ? 7'd99 : set_msec;

  assign tick      = (presc == PMAX);
  assign at_one    = (cnt_h == 5'd0) && (cnt_m == 6'd0) && (cnt_s == 6'd0) && (cnt_c == 7'd1);
  assign cnt_nz    = |{cnt_h, cnt_m, cnt_s, cnt_c};
  assign preset_nz = |{pre_h, pre_m, pre_s, pre_c};

  // Borrow chain for one centisecond decrement; hours never underflow since RUN is never entered at zero
  always_comb begin
    b_c   = (cnt_c == 7'd0);
    dec_c = b_c ? 7'd99 : cnt_c - 7'd1;
    dec_s = cnt_s;
    if (b_c) dec_s = (cnt_s == 6'd0) ? 6'd59 : cnt_s - 6'd1;
    b_s   = b_c && (cnt_s == 6'd0);
    dec_m = cnt_m;
    if (b_s) dec_m = (cnt_m == 6'd0) ? 6'd59 : cnt_m - 6'd1;
    b_m   = b_s && (cnt_m == 6'd0);
    dec_h = cnt_h;
    if (b_m) dec_h = (cnt_h == 5'd0) ? 5'd23 : cnt_h - 5'd1;
  end

  // Next state and datapath strobes; priority clear > load > run_stop > counting
  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_reload = 1'b0;
    do_zero   = 1'b0;
    do_dec    = 1'b0;
    presc_clr = 1'b0;
    presc_run = 1'b0;
    expire    = 1'b0;
    if (clear) begin
      state_nx  = IDLE;
      do_reload = 1'b1;
      presc_clr = 1'b1;
    end else if (load && (state == IDLE || state == DONE)) begin
      state_nx = IDLE;
      do_load  = 1'b1;
    end else if (run_stop) begin
      case (state)
        IDLE:  if (cnt_nz) begin state_nx = RUN; presc_clr = 1'b1; end
        RUN:   state_nx = PAUSE;
        PAUSE: state_nx = RUN;
        DONE:  if (preset_nz) begin state_nx = RUN; do_reload = 1'b1; presc_clr = 1'b1; end
        default: state_nx = IDLE;
      endcase
    end else if (state == RUN) begin
      presc_run = 1'b1;
      if (tick) begin
        if (at_one) begin
          expire = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          do_reload = 1'b1;
`else
          do_zero  = 1'b1;
          state_nx = DONE;
`endif
        end else begin
          do_dec = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Prescaler: runs only in RUN, wraps on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         presc <= '0;
    else if (presc_clr) presc <= '0;
    else if (presc_run) presc <= tick ? '0 : presc + PW'(1);
  end

  // Preset capture of clamped load values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_h <= '0; pre_m <= '0; pre_s <= '0; pre_c <= '0;
    end else if (do_load) begin
      pre_h <= ld_h; pre_m <= ld_m; pre_s <= ld_s; pre_c <= ld_c;
    end
  end

  // Counter registers: load, reload from preset, zero on expiry, or decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h <= '0; cnt_m <= '0; cnt_s <= '0; cnt_c <= '0;
    end else if (do_load) begin
      cnt_h <= ld_h; cnt_m <= ld_m; cnt_s <= ld_s; cnt_c <= ld_c;
    end else if (do_reload) begin
      cnt_h <= pre_h; cnt_m <= pre_m; cnt_s <= pre_s; cnt_c <= pre_c;
    end else if (do_zero) begin
      cnt_h <= '0; cnt_m <= '0; cnt_s <= '0; cnt_c <= '0;
    end else if (do_dec) begin
      cnt_h <= dec_h; cnt_m <= dec_m; cnt_s <= dec_s; cnt_c <= dec_c;
    end
  end

  // Done pulse registered one cycle after the expiring tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= expire;
  end

  assign busy       = (state == RUN) || (state == PAUSE);
  assign low_digit  = option ? {1'b0, cnt_m} : cnt_c;
  assign high_digit = option ? {1'b0, cnt_h} : cnt_s;
endmodule

// File: tb/tb_countdown_timer_dp.sv
// tb/tb_countdown_timer_dp.sv - scoreboard bench for countdown_timer_dp (FCOUNT=4)
module tb_countdown_timer_dp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic [5:0] set_sec = '0;
  logic [6:0] set_msec = '0;
  logic       run_stop = 1'b0;
  logic       clear = 1'b0;
  logic       option = 1'b0;
  logic [6:0] low_digit;
  logic [5:0] high_digit;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int done_seen;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  countdown_timer_dp #(.FCOUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_msec(set_msec),
    .run_stop(run_stop), .clear(clear), .option(option),
    .low_digit(low_digit), .high_digit(high_digit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic b, input logic d, input int h, input int l);
    return {17'd0, b, d, 6'(h), 7'(l)};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, {17'd0, busy, done, high_digit, low_digit}, e.val);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_preset(input int h, input int m, input int s, input int c);
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_msec = 7'(c);
  endtask

  task automatic pulse_load();
    load = 1'b1; step(1); load = 1'b0;
  endtask

  task automatic pulse_run();
    run_stop = 1'b1; step(1); run_stop = 1'b0;
  endtask

  task automatic look(input logic opt, input string tag, input logic [31:0] v);
    option = opt;
    push(tag, v);
    #1;
    pop_check();
  endtask

  initial begin
    option = 1'b0;
    push("reset", pk(0, 0, 0, 0));
    step(2);
    pop_check();
    rst_n = 1'b1;
    step(1);

    // 1: 00:00:01:05 runs out after 105 ticks
    set_preset(0, 0, 1, 5);
    push("load_105", pk(0, 0, 1, 5));
    pulse_load();
    pop_check();
    pulse_run();
    push("first_tick", pk(1, 0, 1, 4));
    step(4);
    pop_check();
    done_seen = 0;
    for (int i = 0; i < 415; i++) begin
      step(1);
      if (done) done_seen++;
    end
    check("no_early_done", 32'(done_seen), 32'd0);
    push("at_one", pk(1, 0, 0, 1));
    #1;
    pop_check();
    push("expire", pk(0, 1, 0, 0));
    step(1);
    pop_check();
    push("done_once", pk(0, 0, 0, 0));
    step(1);
    pop_check();

    // DONE + run_stop reloads preset and runs; clear returns to IDLE
    push("done_rerun", pk(1, 0, 1, 5));
    pulse_run();
    pop_check();
    clear = 1'b1;
    push("clear_from_run", pk(0, 0, 1, 5));
    step(1);
    clear = 1'b0;
    pop_check();

    // 2: 01:00:00:00 borrows through every field on the first tick
    set_preset(1, 0, 0, 0);
    pulse_load();
    look(1'b1, "load_1h", pk(0, 0, 1, 0));
    pulse_run();
    step(4);
    look(1'b1, "borrow_hm", pk(1, 0, 0, 59));
    look(1'b0, "borrow_sc", pk(1, 0, 59, 99));

    // 3: pause freezes count, resume keeps prescaler phase
    step(8);
    step(2);
    run_stop = 1'b1;
    push("pause_frozen", pk(1, 0, 59, 97));
    step(1);
    run_stop = 1'b0;
    step(40);
    pop_check();
    pulse_run();
    push("resume_phase", pk(1, 0, 59, 97));
    step(1);
    pop_check();
    push("resume_tick", pk(1, 0, 59, 96));
    step(1);
    pop_check();
    set_preset(0, 0, 10, 10);
    push("load_in_run", pk(1, 0, 59, 96));
    pulse_load();
    pop_check();

    // 5: clear mid-run restores preset, clear beats run_stop
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    look(1'b1, "clear_mid_run", pk(0, 0, 1, 0));
    clear = 1'b1;
    run_stop = 1'b1;
    step(1);
    clear = 1'b0;
    run_stop = 1'b0;
    look(1'b1, "clear_beats_run", pk(0, 0, 1, 0));

    // 4: all-zero start does nothing; load clamps out-of-range fields
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    option = 1'b0;
    pulse_run();
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (done || busy) done_seen++;
    end
    check("zero_start_idle", 32'(done_seen), 32'd0);
    set_preset(0, 63, 0, 120);
    pulse_load();
    look(1'b1, "clamp_min", pk(0, 0, 0, 59));
    look(1'b0, "clamp_msec", pk(0, 0, 0, 99));
    set_preset(31, 59, 60, 99);
    pulse_load();
    look(1'b1, "clamp_hour", pk(0, 0, 23, 59));
    look(1'b0, "clamp_sec", pk(0, 0, 59, 99));

`ifdef TIMER_AUTORELOAD_EN
    // 6: autoreload from 00:00:00:02
    option = 1'b0;
    set_preset(0, 0, 0, 2);
    pulse_load();
    pulse_run();
    push("auto_tick1", pk(1, 0, 0, 1));
    step(4);
    pop_check();
    push("auto_reload", pk(1, 1, 0, 2));
    step(4);
    pop_check();
    push("auto_done_once", pk(1, 0, 0, 2));
    step(1);
    pop_check();
    push("auto_second", pk(1, 1, 0, 2));
    step(7);
    pop_check();
    step(2);
    rst_n = 1'b0;
    push("async_reset", pk(0, 0, 0, 0));
    #1;
    pop_check();
    rst_n = 1'b1;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
